// File: rtl/digit_entry_pkg.sv
// Shared encodings for the push-button digit entry controller:
// FSM states, button bit positions and the BCD digit ceiling.
package digit_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;
  localparam int BTN_COUNT  = 5;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/press_edge_capture.sv
// Registers button levels once and emits a single-cycle event on each
// observed rising edge; buttons already held when reset releases stay silent.
module press_edge_capture #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] evt_o
);

  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] prev_q;
  logic             primed_q;

  // prev_q keeps its all-ones reset value through the first sample, so a
  // level captured on the first edge after reset is treated as already seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q     <= '0;
      prev_q   <= '1;
      primed_q <= 1'b0;
    end else begin
      in_q     <= btn_i;
      prev_q   <= primed_q ? in_q : '1;
      primed_q <= 1'b1;
    end
  end

  assign evt_o = in_q & ~prev_q;

endmodule

// File: rtl/digit_entry_ctrl.sv
// Cursor-based multi-digit BCD editor driven by five push-buttons, handing
// each finished entry downstream through a valid/ready commit handshake.
module digit_entry_ctrl
  import digit_entry_pkg::*;
#(
  parameter int  DIGITS = 4,
  localparam int CUR_W  = $clog2(DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_center,
  output logic [4*DIGITS-1:0] digits,
  output logic [CUR_W-1:0]    cursor,
  output logic                editing,
  output logic                commit_valid,
  output logic [4*DIGITS-1:0] commit_value,
  input  logic                commit_ready
);

  localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(DIGITS - 1);

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? BCD_MAX : d - 4'd1;
  endfunction

  logic [BTN_COUNT-1:0] btn_lvl;
  logic [BTN_COUNT-1:0] evt;

  assign btn_lvl[BTN_UP]     = btn_up;
  assign btn_lvl[BTN_DOWN]   = btn_down;
  assign btn_lvl[BTN_LEFT]   = btn_left;
  assign btn_lvl[BTN_RIGHT]  = btn_right;
  assign btn_lvl[BTN_CENTER] = btn_center;

  press_edge_capture #(.WIDTH(BTN_COUNT)) u_capture (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_lvl),
    .evt_o (evt)
  );

  state_e              state_q,  state_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [CUR_W-1:0]    cursor_q, cursor_d;
  logic                cvalid_q, cvalid_d;
  logic [4*DIGITS-1:0] cvalue_q, cvalue_d;
  logic [3:0]          cur_digit;

  assign cur_digit = digits_q[{cursor_q, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      cursor_q <= '0;
      cvalid_q <= 1'b0;
      cvalue_q <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      cursor_q <= cursor_d;
      cvalid_q <= cvalid_d;
      cvalue_q <= cvalue_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cursor_d = cursor_q;
    cvalid_d = cvalid_q;
    cvalue_d = cvalue_q;
    unique case (state_q)
      ST_IDLE: begin
        if (evt[BTN_CENTER]) begin
          state_d  = ST_EDIT;
          cursor_d = '0;
        end
      end
      ST_EDIT: begin
        // Strict priority chain: a losing simultaneous event is dropped.
        if (evt[BTN_CENTER]) begin
          cvalue_d = digits_q;
          cvalid_d = 1'b1;
          state_d  = ST_COMMIT;
        end else if (evt[BTN_UP]) begin
          digits_d[{cursor_q, 2'b00} +: 4] = bcd_inc(cur_digit);
        end else if (evt[BTN_DOWN]) begin
          digits_d[{cursor_q, 2'b00} +: 4] = bcd_dec(cur_digit);
        end else if (evt[BTN_LEFT]) begin
          cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + 1'b1;
        end else if (evt[BTN_RIGHT]) begin
          cursor_d = (cursor_q == '0) ? CUR_LAST : cursor_q - 1'b1;
        end
      end
      ST_COMMIT: begin
        if (cvalid_q && commit_ready) begin
          cvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign digits       = digits_q;
  assign cursor       = cursor_q;
  assign editing      = (state_q == ST_EDIT);
  assign commit_valid = cvalid_q;
  assign commit_value = cvalue_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl (DIGITS=4) with hand-computed expectations.
module tb_digit_entry_ctrl;

  localparam int UP = 0, DN = 1, LF = 2, RT = 3, CT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn = '0;
  logic        commit_ready = 1'b0;
  logic [15:0] digits;
  logic [1:0]  cursor;
  logic        editing;
  logic        commit_valid;
  logic [15:0] commit_value;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  digit_entry_ctrl #(.DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up       (btn[UP]),
    .btn_down     (btn[DN]),
    .btn_left     (btn[LF]),
    .btn_right    (btn[RT]),
    .btn_center   (btn[CT]),
    .digits       (digits),
    .cursor       (cursor),
    .editing      (editing),
    .commit_valid (commit_valid),
    .commit_value (commit_value),
    .commit_ready (commit_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One-cycle pulse; returns at the negedge after the update edge.
  task automatic press(input logic [4:0] mask);
    @(negedge clk) btn = mask;
    @(negedge clk) btn = '0;
    @(negedge clk);
  endtask

  task automatic press_n(input logic [4:0] mask, input int n);
    for (int i = 0; i < n; i++) press(mask);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".digits"},  32'(digits), 32'h0);
    chk({tag, ".cursor"},  32'(cursor), 32'h0);
    chk({tag, ".editing"}, 32'(editing), 32'h0);
    chk({tag, ".cvalid"},  32'(commit_valid), 32'h0);
    chk({tag, ".cvalue"},  32'(commit_value), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Long center hold: one event only, so no second (commit) action.
    @(negedge clk) btn = 5'b1 << CT;
    repeat (1000) @(negedge clk);
    chk("hold.editing", 32'(editing), 32'h1);
    chk("hold.cvalid",  32'(commit_valid), 32'h0);
    chk("hold.cursor",  32'(cursor), 32'h0);
    chk("hold.digits",  32'(digits), 32'h0);
    btn = '0;
    @(negedge clk);

    press_n(5'b1 << UP, 12);
    chk("up12", 32'(digits), 32'h0002);
    press_n(5'b1 << DN, 3);
    chk("down3", 32'(digits), 32'h0009);

    press_n(5'b1 << LF, 5);
    chk("left5", 32'(cursor), 32'h1);
    press_n(5'b1 << RT, 2);
    chk("right2", 32'(cursor), 32'h3);
    press(5'b1 << UP);
    chk("up_c3", 32'(digits), 32'h1009);

    press((5'b1 << UP) | (5'b1 << LF));
    chk("prio.digits", 32'(digits), 32'h2009);
    chk("prio.cursor", 32'(cursor), 32'h3);
    repeat (4) @(negedge clk);
    chk("prio.later_cursor", 32'(cursor), 32'h3);
    press(5'b1 << DN);
    chk("down_c3", 32'(digits), 32'h1009);

    // Commit held while the consumer stalls; buttons must be ignored.
    press(5'b1 << CT);
    chk("commit.valid", 32'(commit_valid), 32'h1);
    chk("commit.value", 32'(commit_value), 32'h1009);
    chk("commit.editing", 32'(editing), 32'h0);
    press_n(5'b1 << UP, 4);
    press_n(5'b1 << CT, 2);
    repeat (8) @(negedge clk);
    chk("stall.valid",  32'(commit_valid), 32'h1);
    chk("stall.value",  32'(commit_value), 32'h1009);
    chk("stall.digits", 32'(digits), 32'h1009);
    chk("stall.editing", 32'(editing), 32'h0);
    commit_ready = 1'b1;
    @(negedge clk);
    chk("hs.valid_low", 32'(commit_valid), 32'h0);
    chk("hs.value_kept", 32'(commit_value), 32'h1009);
    chk("hs.idle", 32'(editing), 32'h0);

    // Re-entry resumes the value; ready already high gives one-cycle valid.
    press(5'b1 << CT);
    chk("reenter.editing", 32'(editing), 32'h1);
    chk("reenter.cursor",  32'(cursor), 32'h0);
    chk("reenter.digits",  32'(digits), 32'h1009);
    press_n(5'b1 << UP, 3);
    chk("reenter.up3", 32'(digits), 32'h1002);
    press(5'b1 << CT);
    chk("fast.valid_hi", 32'(commit_valid), 32'h1);
    chk("fast.value", 32'(commit_value), 32'h1002);
    @(negedge clk);
    chk("fast.valid_lo", 32'(commit_valid), 32'h0);
    commit_ready = 1'b0;

    // Button held across reset release must not produce an event.
    rst = 1'b1;
    btn = 5'b1 << CT;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_rst.editing", 32'(editing), 32'h0);
    btn = '0;
    @(negedge clk);
    press(5'b1 << CT);
    chk("after_rst.editing", 32'(editing), 32'h1);

    // Asynchronous reset in the middle of a stalled commit.
    press(5'b1 << UP);
    press(5'b1 << CT);
    chk("pre_abort.valid", 32'(commit_valid), 32'h1);
    chk("pre_abort.digits", 32'(digits), 32'h0001);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
